// File: rtl/mem_pkg.sv
// ----------------------------------------------------------------------------
// mem_pkg: constants and FSM encoding shared by data_memory and the cache controller | rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mem_pkg;

  localparam int LINE_W   = 256;
  localparam int DEPTH    = 512;
  localparam int IDX_W    = 9;
  localparam int OFFSET_W = 5;
  localparam int LATENCY  = 10;
  localparam int CNT_W    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/data_memory.sv
// ----------------------------------------------------------------------------
// data_memory: 512 x 256-bit line memory, fixed-latency whole-line access with ack pulse | rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module data_memory
  import mem_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       addr_i,
  input  logic [LINE_W-1:0] data_i,
  input  logic              enable_i,
  input  logic              write_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o
);

  logic [LINE_W-1:0] memory [0:DEPTH-1];

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ack_q,   ack_d;

  logic [IDX_W-1:0] idx_w;
  logic             unused_addr;

  assign idx_w       = addr_i[OFFSET_W +: IDX_W];
  assign unused_addr = ^{addr_i[31:OFFSET_W+IDX_W], addr_i[OFFSET_W-1:0]};

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      count_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ack_q   <= ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (enable_i) begin
          state_d = WAIT;
          count_d = CNT_W'(1);
        end
      end
      WAIT: begin
        // A dropped request wins over reaching the terminal count.
        if (!enable_i) begin
          state_d = IDLE;
          count_d = '0;
        end else begin
          count_d = count_q + CNT_W'(1);
          if (count_q == CNT_W'(LATENCY - 1)) begin
            state_d = ACK;
          end
        end
      end
      ACK: begin
        state_d = IDLE;
        count_d = '0;
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
    ack_d = (state_d == ACK);
  end

  always_comb begin
    ack_o  = ack_q;
    data_o = ack_q ? memory[idx_w] : '0;
  end

  // Storage has no reset; an asynchronous reset leaves state_q in IDLE so no write fires.
  always_ff @(posedge clk_i) begin
    if ((state_q == ACK) && write_i) begin
      memory[idx_w] <= data_i;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_data_memory.sv
// ----------------------------------------------------------------------------
// tb_data_memory: directed scoreboard bench for data_memory | rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_data_memory;

  logic         clk;
  logic         rst_n;
  logic [31:0]  addr;
  logic [255:0] wdata;
  logic         enable;
  logic         write;
  logic         ack;
  logic [255:0] rdata;

  logic [255:0] model [0:511];
  logic [255:0] sb [$];

  int n_checks = 0;
  int n_err    = 0;

  data_memory dut (
    .clk_i    (clk),
    .rst_i    (rst_n),
    .addr_i   (addr),
    .data_i   (wdata),
    .enable_i (enable),
    .write_i  (write),
    .ack_o    (ack),
    .data_o   (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Issue one request from just after an edge; ack must follow the tenth edge.
  task automatic txn(input string tag, input logic [31:0] a, input logic wr,
                     input logic [255:0] d, input bit hold);
    int           edges;
    bit           early;
    logic [8:0]   idx;
    logic [255:0] exp;
    idx = a[13:5];
    sb.push_back(model[idx]);
    addr   = a;
    wdata  = d;
    write  = wr;
    enable = 1'b1;
    edges  = 0;
    early  = 1'b0;
    while (edges < 20) begin
      tick();
      edges++;
      if (ack === 1'b1) break;
      if (rdata !== '0) early = 1'b1;
    end
    check({tag, "_latency"}, 256'(edges), 256'(10));
    check({tag, "_ack_hi"}, {255'b0, ack}, 256'd1);
    exp = sb.pop_front();
    check({tag, "_data"}, rdata, exp);
    check({tag, "_data_zero_wait"}, {255'b0, early}, 256'd0);
    if (wr) model[idx] = d;
    if (!hold) enable = 1'b0;
    tick();
    check({tag, "_ack_lo"}, {255'b0, ack}, 256'd0);
    check({tag, "_data_lo"}, rdata, '0);
  endtask

  initial begin
    int           acks;
    int           edges;
    logic [255:0] w;

    rst_n  = 1'b0;
    addr   = '0;
    wdata  = '0;
    enable = 1'b0;
    write  = 1'b0;

    for (int i = 0; i < 512; i++) begin
      for (int k = 0; k < 8; k++) w[k*32 +: 32] = $urandom();
      model[i] = w;
    end
    for (int k = 0; k < 16; k++) begin
      model[0][255-16*k -: 16]  = {4{4'(k)}};
      model[32][255-16*k -: 16] = {4'(k), 8'h00, 4'(k)};
    end
    model[2]  = {16{16'hECFA}};
    model[16] = {4{64'h0123_4567_89AB_CDEF}};
    for (int i = 0; i < 512; i++) dut.memory[i] = model[i];

    tick();
    tick();
    check("reset_ack", {255'b0, ack}, 256'd0);
    check("reset_data", rdata, '0);
    rst_n = 1'b1;
    tick();

    // Basic read of preloaded line 0
    txn("rd0", 32'h0000_0000, 1'b0, '0, 1'b0);

    // Write then read back, neighbours untouched
    txn("wr1", 32'h0000_0020, 1'b1, {8{32'hDEAD_BEEF}}, 1'b0);
    check("wr1_mem1", dut.memory[1], {8{32'hDEAD_BEEF}});
    check("wr1_mem0", dut.memory[0], model[0]);
    check("wr1_mem2", dut.memory[2], model[2]);
    txn("rd1", 32'h0000_0020, 1'b0, '0, 1'b0);

    // Aliasing of offset and high address bits
    txn("rd_0x25", 32'h0000_0025, 1'b0, '0, 1'b0);
    txn("rd_0x4040", 32'h0000_4040, 1'b0, '0, 1'b0);
    txn("wr511", 32'h0000_3FE0, 1'b1, {8{32'hCAFE_F00D}}, 1'b0);
    check("wr511_mem511", dut.memory[511], {8{32'hCAFE_F00D}});
    check("wr511_mem510", dut.memory[510], model[510]);
    check("wr511_mem0", dut.memory[0], model[0]);

    // Abort a write after four edges
    addr   = 32'h0000_0400;
    wdata  = {8{32'h1234_5678}};
    write  = 1'b1;
    enable = 1'b1;
    repeat (4) tick();
    enable = 1'b0;
    acks   = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (ack === 1'b1) acks++;
    end
    check("abort_no_ack", 256'(acks), 256'd0);
    check("abort_mem32", dut.memory[32], model[32]);
    txn("rd32_after_abort", 32'h0000_0400, 1'b0, '0, 1'b0);

    // Reset during WAIT of a write
    addr   = 32'h0000_0200;
    wdata  = {8{32'hBAD0_BAD0}};
    write  = 1'b1;
    enable = 1'b1;
    repeat (5) tick();
    #1 rst_n = 1'b0;
    #1 check("rst_wait_ack", {255'b0, ack}, 256'd0);
    enable = 1'b0;
    write  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_wait_mem16", dut.memory[16], model[16]);

    // Reset during the ACK cycle of a write: ack drops at once, no update
    addr   = 32'h0000_0200;
    wdata  = {8{32'hBAD1_BAD1}};
    write  = 1'b1;
    enable = 1'b1;
    edges  = 0;
    while (edges < 20 && ack !== 1'b1) begin
      tick();
      edges++;
    end
    check("rst_ack_seen", {255'b0, ack}, 256'd1);
    #1 rst_n = 1'b0;
    #1 check("rst_ack_drop", {255'b0, ack}, 256'd0);
    check("rst_ack_data", rdata, '0);
    enable = 1'b0;
    write  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_ack_mem16", dut.memory[16], model[16]);
    txn("rd16_after_rst", 32'h0000_0200, 1'b0, '0, 1'b0);

    // Back-to-back: enable held across the ack
    txn("b2b_a", 32'h0000_0040, 1'b0, '0, 1'b1);
    txn("b2b_b", 32'h0000_0060, 1'b1, {8{32'h5A5A_A5A5}}, 1'b0);
    check("b2b_mem3", dut.memory[3], model[3]);
    acks = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (ack === 1'b1) acks++;
    end
    check("b2b_no_extra_ack", 256'(acks), 256'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
